// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Rounded clock cycles per bit; integer math keeps every bit exactly the same length.
  function automatic int bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word visible the cycle after a push into empty.
// A push into a full FIFO succeeds only alongside a pop, otherwise drop_o flags it combinationally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  // The extra MSB on each pointer separates full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && !do_push;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART with configurable framing; tx accepts one word per frame via valid/ready.
// Received words, with their error flags, queue in a FWFT FIFO; words arriving when it is full are dropped.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic                 rs232_tx,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  localparam int             BIT_DIV  = bit_div(CLK_HZ, BAUD);
  localparam int             CW       = $clog2(STOP_BITS * BIT_DIV);
  localparam logic [CW-1:0]  DIV_M1   = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0]  HALF_M1  = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0]  STOP_M1  = CW'(STOP_BITS * BIT_DIV - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
  localparam bit             HAS_PAR  = (PARITY != PAR_NONE);

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  tx_state_e            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 tx_rdy_q;

  rx_state_e            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_perr_q;
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 loop_q;
  logic                 ovr_q;

  logic                 rx_in;
  logic                 rx_s;
  logic                 rx_push;
  logic [DATA_BITS+1:0] rx_wdata;
  logic [DATA_BITS+1:0] rx_rdata;
  logic                 fifo_empty;
  logic                 fifo_drop;

  assign rs232_tx = loop_q | tx_q;
  assign tx_ready = tx_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_shift_q <= tx_data;
            tx_par_q   <= par_of(tx_data);
            tx_rdy_q   <= 1'b0;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == LAST_BIT) begin
              tx_q       <= HAS_PAR ? tx_par_q : 1'b1;
              tx_state_q <= HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == STOP_M1) begin
            tx_cnt_q   <= '0;
            tx_rdy_q   <= 1'b1;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Loopback only changes between frames so neither FSM sees its input switch mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_q <= loopback;
    end else if (tx_state_q == TX_IDLE && rx_state_q == RX_IDLE) begin
      loop_q <= loopback;
    end
  end

  assign rx_in = loop_q ? tx_q : rs232_rx;
  assign rx_s  = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) begin
              rx_perr_q  <= 1'b0;
              rx_state_q <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_perr_q  <= (rx_s != par_of(rx_shift_q));
            rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Every frame is pushed at its stop sample, flagged or not.
  assign rx_push  = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_M1);
  assign rx_wdata = {rx_perr_q, ~rx_s, rx_shift_q};

  uart_sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_ready),
    .rdata_o (rx_rdata),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= fifo_drop;
  end

  assign rx_overrun    = ovr_q;
  assign rx_valid      = !fifo_empty;
  assign rx_data       = rx_rdata[DATA_BITS-1:0];
  assign rx_frame_err  = rx_rdata[DATA_BITS];
  assign rx_parity_err = rx_rdata[DATA_BITS+1];

endmodule
